adder: RTL and testbench

//   Registered WIDTH-bit binary adder with carry-in and carry-out.

---
 rtl/adder.sv | 73 +++++++
 tb/tb_adder.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/adder.sv
// Registered WIDTH-bit adder: {carry_out, z} <= a + b + carry_in, one cycle latency.
// The sum comes from a carry-lookahead core of 4-bit groups rippled group to group.
module adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] z,
    output logic             carry_out
);

    localparam int NG   = (WIDTH + 3) / 4;
    localparam int PW   = NG * 4;
    // Position of the carry out of bit WIDTH-1 within the last group (1..4).
    localparam int LAST = WIDTH - 4 * (NG - 1);

    logic [PW-1:0]    a_pad;
    logic [PW-1:0]    b_pad;
    logic [PW-1:0]    sum_pad;
    logic [3:0]       g4;
    logic [3:0]       p4;
    logic [4:0]       gc;
    logic             grp_g;
    logic             grp_p;
    logic             cin_grp;
    logic [WIDTH-1:0] sum_next;
    logic             carry_next;

    always_comb begin
        // Zero padding makes the unused bits of a partial last group g=0, p=0.
        a_pad   = PW'(a);
        b_pad   = PW'(b);
        sum_pad = '0;
        g4      = '0;
        p4      = '0;
        gc      = '0;
        grp_g   = 1'b0;
        grp_p   = 1'b0;
        cin_grp = carry_in;
        for (int k = 0; k < NG; k++) begin
            g4 = a_pad[4*k +: 4] & b_pad[4*k +: 4];
            p4 = a_pad[4*k +: 4] ^ b_pad[4*k +: 4];
            gc[0] = cin_grp;
            gc[1] = g4[0] | (p4[0] & cin_grp);
            gc[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & cin_grp);
            gc[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
                  | (p4[2] & p4[1] & p4[0] & cin_grp);
            grp_g = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
                  | (p4[3] & p4[2] & p4[1] & g4[0]);
            grp_p = &p4;
            gc[4] = grp_g | (grp_p & cin_grp);
            sum_pad[4*k +: 4] = p4 ^ gc[3:0];
            cin_grp = gc[4];
        end
        sum_next   = WIDTH'(sum_pad);
        carry_next = gc[LAST];
    end

    // No handshake: operands are sampled every edge, result valid one edge later.
    always_ff @(posedge clk) begin
        if (reset) begin
            z         <= '0;
            carry_out <= 1'b0;
        end else begin
            z         <= sum_next;
            carry_out <= carry_next;
        end
    end

endmodule

// File: tb/tb_adder.sv
// Bench for adder: directed vectors on WIDTH=8 plus random traffic on WIDTH=1,5,8,13,32,
// with a scoreboard queue per instance and a monitor that checks one cycle after issue.
module tb_adder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic [0:0]  a1,  b1;   logic ci1;  logic [0:0]  z1;  logic co1;
    logic [4:0]  a5,  b5;   logic ci5;  logic [4:0]  z5;  logic co5;
    logic [7:0]  a8,  b8;   logic ci8;  logic [7:0]  z8;  logic co8;
    logic [12:0] a13, b13;  logic ci13; logic [12:0] z13; logic co13;
    logic [31:0] a32, b32;  logic ci32; logic [31:0] z32; logic co32;

    logic [1:0]  exp_q1[$];
    logic [5:0]  exp_q5[$];
    logic [8:0]  exp_q8[$];
    logic [13:0] exp_q13[$];
    logic [32:0] exp_q32[$];

    int   total = 0;
    int   bad   = 0;
    logic issued = 1'b0;
    logic out_vld = 1'b0;

    adder #(.WIDTH(1))  u_add1  (.clk(clk), .reset(reset), .a(a1),  .b(b1),  .carry_in(ci1),  .z(z1),  .carry_out(co1));
    adder #(.WIDTH(5))  u_add5  (.clk(clk), .reset(reset), .a(a5),  .b(b5),  .carry_in(ci5),  .z(z5),  .carry_out(co5));
    adder #(.WIDTH(8))  u_add8  (.clk(clk), .reset(reset), .a(a8),  .b(b8),  .carry_in(ci8),  .z(z8),  .carry_out(co8));
    adder #(.WIDTH(13)) u_add13 (.clk(clk), .reset(reset), .a(a13), .b(b13), .carry_in(ci13), .z(z13), .carry_out(co13));
    adder #(.WIDTH(32)) u_add32 (.clk(clk), .reset(reset), .a(a32), .b(b32), .carry_in(ci32), .z(z32), .carry_out(co32));

    // Clock / reset
    always #5 clk = ~clk;

    // Scoreboard check
    task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_empty(input string name, input int size);
        total++;
        if (size == 0) begin
            bad++;
            $display("FAIL %s got=empty-queue expected=entry at %0t", name, $time);
        end
    endtask

    // Driver: one operand set per cycle on every instance; the 8-bit one takes the
    // directed vector and its hand-computed result, the others get random operands.
    task automatic issue(input logic rst, input logic [7:0] a, input logic [7:0] b,
                         input logic ci, input logic [8:0] exp8);
        logic [1:0]  e1;
        logic [5:0]  e5;
        logic [13:0] e13;
        logic [32:0] e32;
        @(posedge clk);
        #1;
        reset = rst;
        a8 = a; b8 = b; ci8 = ci;
        a1  = 1'($urandom);  b1  = 1'($urandom);  ci1  = 1'($urandom);
        a5  = 5'($urandom);  b5  = 5'($urandom);  ci5  = 1'($urandom);
        a13 = 13'($urandom); b13 = 13'($urandom); ci13 = 1'($urandom);
        a32 = $urandom;      b32 = $urandom;      ci32 = 1'($urandom);
        e1  = {1'b0, a1}  + {1'b0, b1}  + 2'(ci1);
        e5  = {1'b0, a5}  + {1'b0, b5}  + 6'(ci5);
        e13 = {1'b0, a13} + {1'b0, b13} + 14'(ci13);
        e32 = {1'b0, a32} + {1'b0, b32} + 33'(ci32);
        exp_q8.push_back(exp8);
        exp_q1.push_back(rst ? 2'd0 : e1);
        exp_q5.push_back(rst ? 6'd0 : e5);
        exp_q13.push_back(rst ? 14'd0 : e13);
        exp_q32.push_back(rst ? 33'd0 : e32);
        issued = 1'b1;
    endtask

    task automatic issue_rand8();
        logic [7:0] a, b;
        logic       ci;
        logic [8:0] e;
        a  = 8'($urandom);
        b  = 8'($urandom);
        ci = 1'($urandom);
        e  = {1'b0, a} + {1'b0, b} + 9'(ci);
        issue(1'b0, a, b, ci, e);
    endtask

    // Monitor: results appear one edge after the operands were sampled.
    always @(posedge clk) out_vld <= issued;

    always @(negedge clk) begin
        if (out_vld) begin
            check_empty("q8", exp_q8.size());
            if (exp_q8.size() != 0)  check("w8",  33'({co8, z8}),   33'(exp_q8.pop_front()));
            check_empty("q1", exp_q1.size());
            if (exp_q1.size() != 0)  check("w1",  33'({co1, z1}),   33'(exp_q1.pop_front()));
            check_empty("q5", exp_q5.size());
            if (exp_q5.size() != 0)  check("w5",  33'({co5, z5}),   33'(exp_q5.pop_front()));
            check_empty("q13", exp_q13.size());
            if (exp_q13.size() != 0) check("w13", 33'({co13, z13}), 33'(exp_q13.pop_front()));
            check_empty("q32", exp_q32.size());
            if (exp_q32.size() != 0) check("w32", {co32, z32},      exp_q32.pop_front());
        end
    end

    initial begin
        a1 = '0; b1 = '0; ci1 = 1'b0;
        a5 = '0; b5 = '0; ci5 = 1'b0;
        a8 = '0; b8 = '0; ci8 = 1'b0;
        a13 = '0; b13 = '0; ci13 = 1'b0;
        a32 = '0; b32 = '0; ci32 = 1'b0;

        // Reset for two cycles with random operands
        issue(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 9'h000);
        issue(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 9'h000);

        // Basic sums
        issue(1'b0, 8'h12, 8'h34, 1'b0, 9'h046);
        issue(1'b0, 8'h12, 8'h34, 1'b1, 9'h047);

        // Boundaries
        issue(1'b0, 8'hFF, 8'h00, 1'b1, 9'h100);
        issue(1'b0, 8'hFF, 8'hFF, 1'b1, 9'h1FF);
        issue(1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
        issue(1'b0, 8'h0F, 8'h01, 1'b0, 9'h010);
        issue(1'b0, 8'hF0, 8'h10, 1'b0, 9'h100);

        // Mid-stream reset, then release with the same operands
        issue(1'b1, 8'h80, 8'h80, 1'b0, 9'h000);
        issue(1'b0, 8'h80, 8'h80, 1'b0, 9'h100);

        // Held operands
        for (int i = 0; i < 5; i++) issue(1'b0, 8'hA5, 8'h5A, 1'b1, 9'h100);

        // Random traffic
        for (int i = 0; i < 1100; i++) issue_rand8();

        @(posedge clk);
        #1;
        issued = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        total++;
        if (exp_q8.size() + exp_q1.size() + exp_q5.size() + exp_q13.size() + exp_q32.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d leftover expected=0", exp_q8.size() + exp_q1.size()
                     + exp_q5.size() + exp_q13.size() + exp_q32.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
